stream_scoreboard: RTL and testbench
====================================

Name: stream_scoreboard

Overview:
Synthesizable in-line checker for a streaming DUT that emits one word per cycle, qualified by a valid strobe. Expected words are queued in an internal FIFO. Each observed DUT word pops the FIFO head, is compared against it, and is tallied as a match or an error. It replaces file-based compare with a parametrised hardware scoreboard usable in simulation and on FPGA.
- Adds: configurable width and depth, depth tracking, overflow/underflow detection, saturating counters, sticky pass/fail state, first-error capture.

Parameters:
- DATA_W, 32, width of expected and observed words.
- DEPTH, 16, expected-FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the match and error counters.

Ports:
- clk  in  1  clock; all state on the rising edge.
- n_rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear: FIFO, counters, flags and state to reset values.
- exp_valid  in  1  push exp_data into the FIFO.
- exp_data  in  DATA_W  expected word.
- obs_valid  in  1  DUT output valid; triggers a compare.
- obs_data  in  DATA_W  DUT output word.
- res_valid  out  1  one-cycle pulse: a compare result is available.
- res_match  out  1  result of that compare (1 = equal).
- res_got  out  DATA_W  observed word of that compare.
- res_exp  out  DATA_W  expected word of that compare (0 on underflow).
- match_count  out  CNT_W  saturating count of matches.
- error_count  out  CNT_W  saturating count of mismatches plus underflows.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: obs_valid arrived with the FIFO empty.
- state  out  2  0 IDLE, 1 PASS, 2 FAIL.
- first_err_got  out  DATA_W  obs_data of the first error.
- first_err_exp  out  DATA_W  expected word of the first error.

Behaviour:
- Reset (n_rst=0, async) and clear (sync): all outputs 0, FIFO empty, state IDLE. clear has priority over all same-cycle events.
- Push: exp_valid with fill<DEPTH writes at the write pointer. Pointers wrap modulo DEPTH.
- Push when full: accepted only if a pop occurs in the same cycle. Otherwise the word is dropped and overflow is set.
- Compare: obs_valid with fill>0 pops the head and compares all DATA_W bits.
  - One cycle later: res_valid=1, res_match, res_got, res_exp registered.
  - Latency from obs_valid to result is 1 cycle.
- Underflow: obs_valid with fill=0 is never bypassed from a same-cycle push; the push is stored.
  - Result: res_valid=1, res_match=0, res_exp=0, underflow set, error counted.
- Simultaneous push and pop: fill is unchanged.
- Counters: saturate at 2^CNT_W−1 and never wrap.
- State machine:
  - IDLE→PASS on the first matching compare.
  - IDLE→FAIL or PASS→FAIL on any error.
  - FAIL is sticky until clear or reset.
  - Overflow does not change state.
- First-error capture: first_err_* load only on the transition into FAIL; held thereafter.
- Reset asserted mid-stream discards in-flight results; no res_valid is issued for the cycle after reset release.

Optional Feature:
- Macro: STREAM_SCOREBOARD_MASK_EN.
- Defined: adds input exp_mask [DATA_W], pushed alongside exp_data and stored per entry. The compare checks only bits where mask=1; res_exp shows the unmasked expected word.
- Undefined: no exp_mask port; full-width compare.

Decomposition:
- Package sb_pkg holds the state enum (SB_IDLE, SB_PASS, SB_FAIL) and a saturating-increment function.
- One sub-module, sb_fifo: parametrised synchronous FIFO with push, pop, full, empty and fill. It carries the mask field when the macro is defined.

Test Plan:
- Push 0x0001_0002, 0x0003_0004, then observe the same two words → two res_valid pulses, res_match=1, match_count=2, state=PASS, fill=0.
- Push 0xDEAD_BEEF, observe 0xDEAD_BEEE → res_match=0, error_count=1, state=FAIL, first_err_got=0xDEAD_BEEE, first_err_exp=0xDEAD_BEEF. A later match leaves state FAIL.
- Observe 0x1234_5678 with the FIFO empty and a same-cycle push of 0x1234_5678 → underflow=1, res_exp=0, error_count=1, fill=1.
- DEPTH=16:
  - 17 pushes → fill=16, overflow=1, 17th word absent.
  - Push+pop when full → fill stays 16, no new overflow.
- CNT_W=4: 20 matching compares → match_count=15; clear → all counters 0, state IDLE.
- With the macro: mask 0xFFFF_0000, exp 0xABCD_0000, obs 0xABCD_1111 → res_match=1.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and helpers for the stream scoreboard: result state enum and
// a saturating increment usable at any counter width up to 32 bits.
package sb_pkg;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_PASS = 2'd1,
        SB_FAIL = 2'd2
    } sb_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [32:0] vmax;
        vmax = (33'd1 << w) - 33'd1;
        return ({1'b0, v} == vmax) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/stream_scoreboard_if.sv
// Expected/observed stream and per-compare result bus of the scoreboard.
// STREAM_SCOREBOARD_MASK_EN adds a per-word compare mask on the expected side.
interface stream_scoreboard_if #(
    parameter int DATA_W = 32
);
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
`ifdef STREAM_SCOREBOARD_MASK_EN
    logic [DATA_W-1:0] exp_mask;
`endif
    logic              obs_valid;
    logic [DATA_W-1:0] obs_data;
    logic              res_valid;
    logic              res_match;
    logic [DATA_W-1:0] res_got;
    logic [DATA_W-1:0] res_exp;

`ifdef STREAM_SCOREBOARD_MASK_EN
    modport master (output exp_valid, exp_data, exp_mask, obs_valid, obs_data,
                    input  res_valid, res_match, res_got, res_exp);
    modport slave  (input  exp_valid, exp_data, exp_mask, obs_valid, obs_data,
                    output res_valid, res_match, res_got, res_exp);
`else
    modport master (output exp_valid, exp_data, obs_valid, obs_data,
                    input  res_valid, res_match, res_got, res_exp);
    modport slave  (input  exp_valid, exp_data, obs_valid, obs_data,
                    output res_valid, res_match, res_got, res_exp);
`endif

endinterface

// File: rtl/sb_fifo.sv
// Synchronous FIFO of expected entries; a push while full is taken only
// when a pop frees a slot in the same cycle.
module sb_fifo #(
    parameter  int W     = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int FW    = AW + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [FW-1:0] fill
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          push_ok, pop_ok;

    assign empty   = (fill == '0);
    assign full    = (fill == FW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            fill <= fill + FW'(push_ok) - FW'(pop_ok);
        end
    end

    // Storage needs no reset: pointers and fill define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/stream_scoreboard.sv
// In-line stream checker: queues expected words, compares each observed word
// against the FIFO head. STREAM_SCOREBOARD_MASK_EN enables per-word bit masks.
module stream_scoreboard
    import sb_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    parameter  int CNT_W  = 16,
    localparam int FW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    stream_scoreboard_if.slave sif,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  error_count,
    output logic [FW-1:0]     fill,
    output logic              overflow,
    output logic              underflow,
    output logic [1:0]        state,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp
);
`ifdef STREAM_SCOREBOARD_MASK_EN
    localparam int EW = 2 * DATA_W;
`else
    localparam int EW = DATA_W;
`endif

    logic [EW-1:0]     wdata, rdata;
    logic [DATA_W-1:0] head_data, head_mask;
    logic              full, empty, pop, hit, miss;
    sb_state_e         state_q, state_d;

`ifdef STREAM_SCOREBOARD_MASK_EN
    assign wdata     = {sif.exp_mask, sif.exp_data};
    assign head_data = rdata[DATA_W-1:0];
    assign head_mask = rdata[EW-1:DATA_W];
`else
    assign wdata     = sif.exp_data;
    assign head_data = rdata;
    assign head_mask = '1;
`endif

    sb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .push  (sif.exp_valid),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );

    // An observe on an empty FIFO is an underflow miss, never a bypass.
    assign pop  = sif.obs_valid & ~empty;
    assign hit  = pop & (((sif.obs_data ^ head_data) & head_mask) == '0);
    assign miss = sif.obs_valid & ~hit;

    always_comb begin
        state_d = state_q;
        if (miss)                         state_d = SB_FAIL;
        else if (hit && state_q == SB_IDLE) state_d = SB_PASS;
    end

    assign state = state_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= SB_IDLE;
            sif.res_valid <= 1'b0;
            sif.res_match <= 1'b0;
            sif.res_got   <= '0;
            sif.res_exp   <= '0;
            match_count   <= '0;
            error_count   <= '0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            first_err_got <= '0;
            first_err_exp <= '0;
        end else if (clear) begin
            state_q       <= SB_IDLE;
            sif.res_valid <= 1'b0;
            sif.res_match <= 1'b0;
            sif.res_got   <= '0;
            sif.res_exp   <= '0;
            match_count   <= '0;
            error_count   <= '0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            first_err_got <= '0;
            first_err_exp <= '0;
        end else begin
            state_q       <= state_d;
            sif.res_valid <= sif.obs_valid;
            if (sif.obs_valid) begin
                sif.res_match <= hit;
                sif.res_got   <= sif.obs_data;
                sif.res_exp   <= pop ? head_data : '0;
            end
            if (hit)  match_count <= CNT_W'(sat_inc(32'(match_count), CNT_W));
            if (miss) error_count <= CNT_W'(sat_inc(32'(error_count), CNT_W));
            if (sif.exp_valid && full && !pop) overflow <= 1'b1;
            if (sif.obs_valid && empty)        underflow <= 1'b1;
            if (miss && state_q != SB_FAIL) begin
                first_err_got <= sif.obs_data;
                first_err_exp <= pop ? head_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_stream_scoreboard.sv
// Directed + random bench for stream_scoreboard against a queue-based model.
module tb_stream_scoreboard;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int FW     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    stream_scoreboard_if #(.DATA_W(DATA_W)) sif ();
    logic [CNT_W-1:0]  match_count, error_count;
    logic [FW-1:0]     fill;
    logic              overflow, underflow;
    logic [1:0]        state;
    logic [DATA_W-1:0] first_err_got, first_err_exp;

    stream_scoreboard #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .sif           (sif),
        .match_count   (match_count),
        .error_count   (error_count),
        .fill          (fill),
        .overflow      (overflow),
        .underflow     (underflow),
        .state         (state),
        .first_err_got (first_err_got),
        .first_err_exp (first_err_exp)
    );

    logic [DATA_W-1:0] mq_d[$];
    logic [DATA_W-1:0] mq_m[$];
    int                m_match, m_err, m_state;
    bit                m_ovf, m_udf, e_rv, e_rm;
    logic [DATA_W-1:0] m_feg, m_fee, e_rg, e_re;
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic m_reset();
        mq_d.delete();
        mq_m.delete();
        m_match = 0; m_err = 0; m_state = 0;
        m_ovf = 0; m_udf = 0; e_rv = 0; e_rm = 0;
        m_feg = '0; m_fee = '0; e_rg = '0; e_re = '0;
    endtask

    task automatic check_all();
        chk("res_valid", 64'(sif.res_valid), 64'(e_rv));
        if (e_rv) begin
            chk("res_match", 64'(sif.res_match), 64'(e_rm));
            chk("res_got", 64'(sif.res_got), 64'(e_rg));
            chk("res_exp", 64'(sif.res_exp), 64'(e_re));
        end
        chk("match_count", 64'(match_count), 64'(m_match));
        chk("error_count", 64'(error_count), 64'(m_err));
        chk("fill", 64'(fill), 64'(mq_d.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_udf));
        chk("state", 64'(state), 64'(m_state));
        chk("first_err_got", 64'(first_err_got), 64'(m_feg));
        chk("first_err_exp", 64'(first_err_exp), 64'(m_fee));
    endtask

    // One clock: drive at negedge, advance the model at the edge, compare after.
    task automatic step(input bit pv, input logic [DATA_W-1:0] pd, input logic [DATA_W-1:0] pm,
                        input bit ov, input logic [DATA_W-1:0] od, input bit clr);
        int                n;
        bit                pop;
        logic [DATA_W-1:0] hd, hm;
        @(negedge clk);
        sif.exp_valid = pv;
        sif.exp_data  = pd;
`ifdef STREAM_SCOREBOARD_MASK_EN
        sif.exp_mask  = pm;
`endif
        sif.obs_valid = ov;
        sif.obs_data  = od;
        clear         = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            m_reset();
        end else begin
            n   = mq_d.size();
            pop = ov && n > 0;
            hd  = '0;
            hm  = '1;
            if (pop) begin
                hd = mq_d.pop_front();
                hm = mq_m.pop_front();
            end
            if (pv) begin
                if (n < DEPTH || pop) begin
                    mq_d.push_back(pd);
`ifdef STREAM_SCOREBOARD_MASK_EN
                    mq_m.push_back(pm);
`else
                    mq_m.push_back('1);
`endif
                end else m_ovf = 1;
            end
            e_rv = ov;
            if (ov) begin
                e_rg = od;
                e_re = hd;
                e_rm = pop && (((od ^ hd) & hm) == '0);
                if (!pop) m_udf = 1;
                if (e_rm) begin
                    if (m_match < CMAX) m_match++;
                    if (m_state == 0) m_state = 1;
                end else begin
                    if (m_err < CMAX) m_err++;
                    if (m_state != 2) begin
                        m_feg = od; m_fee = hd; m_state = 2;
                    end
                end
            end
        end
        check_all();
    endtask

    initial begin
        logic [DATA_W-1:0] v, od;
        bit                ov;
        sif.exp_valid = 0; sif.exp_data = '0; sif.obs_valid = 0; sif.obs_data = '0;
`ifdef STREAM_SCOREBOARD_MASK_EN
        sif.exp_mask = '1;
`endif
        m_reset();
        #12;
        check_all();
        chk("rst_res_match", 64'(sif.res_match), 64'd0);
        chk("rst_res_got", 64'(sif.res_got), 64'd0);
        chk("rst_res_exp", 64'(sif.res_exp), 64'd0);
        @(negedge clk);
        n_rst = 1;

        // two matching words
        step(1, 32'h0001_0002, '1, 0, '0, 0);
        step(1, 32'h0003_0004, '1, 0, '0, 0);
        step(0, '0, '1, 1, 32'h0001_0002, 0);
        step(0, '0, '1, 1, 32'h0003_0004, 0);
        step(0, '0, '1, 0, '0, 0);

        // mismatch, then a later match keeps FAIL
        step(1, 32'hDEAD_BEEF, '1, 0, '0, 0);
        step(0, '0, '1, 1, 32'hDEAD_BEEE, 0);
        step(1, 32'h5555_AAAA, '1, 0, '0, 0);
        step(0, '0, '1, 1, 32'h5555_AAAA, 0);

        // clear wins over same-cycle push and observe
        step(1, 32'h1111_1111, '1, 1, 32'h2222_2222, 1);

        // underflow with same-cycle push: push stored, not bypassed
        step(1, 32'h1234_5678, '1, 1, 32'h1234_5678, 0);
        step(0, '0, '1, 1, 32'h1234_5678, 0);
        step(0, '0, '1, 0, '0, 1);

        // fill to DEPTH, push+pop when full, dropped push, then drain
        for (int i = 0; i < DEPTH; i++) step(1, 32'hA000_0000 + i, '1, 0, '0, 0);
        step(1, 32'hB000_0000, '1, 1, 32'hA000_0000, 0);
        step(1, 32'hC000_0000, '1, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, '0, '1, 1, mq_d[0], 0);
        step(0, '0, '1, 0, '0, 1);

        // counter saturation
        for (int i = 0; i < 20; i++) begin
            v = $urandom;
            step(1, v, '1, 0, '0, 0);
            step(0, '0, '1, 1, v, 0);
        end
        step(0, '0, '1, 0, '0, 1);

`ifdef STREAM_SCOREBOARD_MASK_EN
        step(1, 32'hABCD_0000, 32'hFFFF_0000, 0, '0, 0);
        step(0, '0, '1, 1, 32'hABCD_1111, 0);
        step(1, 32'hABCD_0000, 32'hFFFF_0000, 0, '0, 0);
        step(0, '0, '1, 1, 32'hABCE_0000, 0);
        step(0, '0, '1, 0, '0, 1);
`endif

        // randomized traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            ov = ($urandom_range(0, 2) == 0);
            od = (mq_d.size() > 0 && $urandom_range(0, 7) != 0) ? mq_d[0] : DATA_W'($urandom);
            step(bit'($urandom_range(0, 1)), $urandom, $urandom | $urandom, ov, od,
                 $urandom_range(0, 99) == 0);
        end

        // async reset right after a compare edge discards that result
        step(1, 32'h7777_0000, '1, 0, '0, 0);
        @(negedge clk);
        sif.exp_valid = 0;
        sif.obs_valid = 1;
        sif.obs_data  = 32'h7777_0000;
        @(posedge clk);
        #2;
        n_rst = 0;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        sif.obs_valid = 0;
        n_rst = 1;
        step(0, '0, '1, 0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
